uart_tx_sched: RTL and testbench

- Round-robin scheduler that shares one uart_tx serializer between N byte requesters.
- Accepts bytes over per-requester valid/ready and launches each byte with a one-cycle send_en pulse.
- Waits for tx_done, then enforces an inter-frame gap before the next launch.
- Owns the serializer's baud configuration and applies changes only between frames.

---
 rtl/uart_ctrl_pkg.sv | 19 +
 rtl/uart_tx_sched_rr_arbiter.sv | 34 +++
 rtl/uart_tx_sched.sv | 161 ++++++++++++++++
 tb/tb_uart_tx_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types for the UART transmit scheduler: FSM state encoding and baud codes.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        GAP       = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        BAUD_9600   = 3'd0,
        BAUD_19200  = 3'd1,
        BAUD_38400  = 3'd2,
        BAUD_57600  = 3'd3,
        BAUD_115200 = 3'd4
    } baud_e;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: searches req starting at ptr and wrapping,
// returning a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    grant_idx,
    output logic             any_grant
);

    int idx_s;

    // First requester found at or after ptr wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        idx_s     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = (int'(ptr) + k) % N_REQ;
            if (!any_grant && req[idx_s]) begin
                grant[idx_s] = 1'b1;
                grant_idx    = IW'(idx_s);
                any_grant    = 1'b1;
            end else begin
                any_grant = any_grant;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx serializer among N_REQ byte requesters.
// Optional WAIT_DONE watchdog enabled by defining UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_sched
    import uart_ctrl_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 65535,
    localparam int IW = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*8-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [2:0]           cfg_baud_set,
    input  logic                 tx_done,
    input  logic                 uart_state,
    output logic [7:0]           data_byte,
    output logic                 send_en,
    output logic [2:0]           baud_set,
    output logic [IW-1:0]        grant_id,
    output logic                 busy,
    output logic                 tx_err
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e             state_r;
    state_e             next_state_s;
    logic [IW-1:0]      ptr_r;
    logic [GW-1:0]      gap_cnt_r;
    logic [N_REQ-1:0]   gnt_s;
    logic [IW-1:0]      gnt_idx_s;
    logic               any_s;
    logic               timeout_hit_s;
    logic [N_REQ-1:0]   req_ready_r;
    logic [7:0]         data_byte_r;
    logic               send_en_r;
    logic [2:0]         baud_set_r;
    logic [IW-1:0]      grant_id_r;
    logic               busy_r;
    logic               tx_err_r;
    logic               unused_uart_state_s;

    // The serializer busy flag is observed only; the FSM never waits on it.
    assign unused_uart_state_s = uart_state;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_r),
        .grant     (gnt_s),
        .grant_idx (gnt_idx_s),
        .any_grant (any_s)
    );

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_cnt_r;

    assign timeout_hit_s = (state_r == WAIT_DONE) && (wd_cnt_r == TW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter: cleared on the way into WAIT_DONE, counts while waiting.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wd_cnt_r <= '0;
            tx_err_r <= 1'b0;
        end else begin
            tx_err_r <= timeout_hit_s && !tx_done;
            if (state_r == LAUNCH) begin
                wd_cnt_r <= '0;
            end else if (state_r == WAIT_DONE) begin
                wd_cnt_r <= wd_cnt_r + TW'(1);
            end
        end
    end
`else
    localparam int UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign timeout_hit_s = 1'b0;
    assign tx_err_r      = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; tx_done outside WAIT_DONE has no effect.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) next_state_s = LAUNCH;
                else       next_state_s = IDLE;
            end
            LAUNCH: next_state_s = WAIT_DONE;
            WAIT_DONE: begin
                if (tx_done)            next_state_s = GAP;
                else if (timeout_hit_s) next_state_s = GAP;
                else                    next_state_s = WAIT_DONE;
            end
            GAP: begin
                if (gap_cnt_r == '0) next_state_s = IDLE;
                else                 next_state_s = GAP;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Registered outputs, pointer and gap counter; baud_set only tracks cfg while idle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            req_ready_r <= '0;
            data_byte_r <= 8'h00;
            send_en_r   <= 1'b0;
            baud_set_r  <= BAUD_9600;
            grant_id_r  <= '0;
            busy_r      <= 1'b0;
            ptr_r       <= '0;
            gap_cnt_r   <= '0;
        end else begin
            req_ready_r <= '0;
            send_en_r   <= 1'b0;
            busy_r      <= (next_state_s != IDLE);
            case (state_r)
                IDLE: begin
                    baud_set_r <= cfg_baud_set;
                    if (any_s) begin
                        req_ready_r <= gnt_s;
                        send_en_r   <= 1'b1;
                        data_byte_r <= req_data[{gnt_idx_s, 3'b000} +: 8];
                        grant_id_r  <= gnt_idx_s;
                    end
                end
                LAUNCH: begin
                    ptr_r <= (grant_id_r == IW'(N_REQ - 1)) ? '0 : grant_id_r + IW'(1);
                end
                WAIT_DONE: begin
                    if (next_state_s == GAP) gap_cnt_r <= GW'(GAP_CYCLES - 1);
                end
                GAP: begin
                    if (gap_cnt_r != '0) gap_cnt_r <= gap_cnt_r - GW'(1);
                end
                default: gap_cnt_r <= '0;
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign data_byte = data_byte_r;
    assign send_en   = send_en_r;
    assign baud_set  = baud_set_r;
    assign grant_id  = grant_id_r;
    assign busy      = busy_r;
    assign tx_err    = tx_err_r;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: table of single frames plus hand-written
// sequences for baud freezing, reset mid-frame and (when enabled) the watchdog.
module tb_uart_tx_sched;
    import uart_ctrl_pkg::*;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic [N-1:0]  req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic [2:0]    cfg_baud_set;
    logic          tx_done;
    logic          uart_state;
    logic [7:0]    data_byte;
    logic          send_en;
    logic [2:0]    baud_set;
    logic [1:0]    grant_id;
    logic          busy;
    logic          tx_err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [N-1:0] pending;

    uart_tx_sched #(.N_REQ(N), .GAP_CYCLES(2), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .cfg_baud_set(cfg_baud_set), .tx_done(tx_done),
        .uart_state(uart_state), .data_byte(data_byte), .send_en(send_en),
        .baud_set(baud_set), .grant_id(grant_id), .busy(busy), .tx_err(tx_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_send"},  32'(send_en),   32'd0);
        check({tag, "_byte"},  32'(data_byte), 32'd0);
        check({tag, "_baud"},  32'(baud_set),  32'd0);
        check({tag, "_gid"},   32'(grant_id),  32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_err"},   32'(tx_err),    32'd0);
    endtask

    task automatic wait_grant(output bit ok, output int lat);
        ok  = 1'b0;
        lat = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            lat++;
            if (req_ready != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expect a grant to exp_gnt, complete the frame with tx_done and check the gap.
    task automatic run_frame(input int exp_gnt, input logic [7:0] exp_byte);
        bit ok;
        int lat;
        wait_grant(ok, lat);
        check("grant_seen", 32'(ok), 32'd1);
        if (ok) begin
            check("grant_lat",  32'(lat),       32'd1);
            check("ready",      32'(req_ready), 32'(4'b0001 << exp_gnt));
            check("send_en",    32'(send_en),   32'd1);
            check("data_byte",  32'(data_byte), 32'(exp_byte));
            check("grant_id",   32'(grant_id),  32'(exp_gnt));
            check("busy_launch", 32'(busy),     32'd1);
            pending[exp_gnt] = 1'b0;
            req_valid = pending;
            @(negedge clk);
            check("send_pulse",  32'(send_en),   32'd0);
            check("ready_pulse", 32'(req_ready), 32'd0);
            repeat (2) @(negedge clk);
            check("byte_hold",  32'(data_byte), 32'(exp_byte));
            check("err_idle",   32'(tx_err),    32'd0);
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            check("busy_gap1", 32'(busy), 32'd1);
            @(negedge clk);
            check("busy_gap2", 32'(busy), 32'd1);
            @(negedge clk);
            check("busy_end",  32'(busy), 32'd0);
        end
    endtask

    typedef struct {
        logic [N-1:0]   add;
        logic [N*8-1:0] data;
        int             exp_gnt;
        logic [7:0]     exp_byte;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bit ok;
        int lat;
        int cnt;

        vecs[0]  = '{4'b0001, 32'h000000A5, 0, 8'hA5};
        vecs[1]  = '{4'b1000, 32'h44332211, 3, 8'h44};
        vecs[2]  = '{4'b1111, 32'h44332211, 0, 8'h11};
        vecs[3]  = '{4'b0001, 32'h44332211, 1, 8'h22};
        vecs[4]  = '{4'b0010, 32'h44332211, 2, 8'h33};
        vecs[5]  = '{4'b0100, 32'h44332211, 3, 8'h44};
        vecs[6]  = '{4'b1000, 32'h44332211, 0, 8'h11};
        vecs[7]  = '{4'b0000, 32'h44332211, 1, 8'h22};
        vecs[8]  = '{4'b0000, 32'h44332211, 2, 8'h33};
        vecs[9]  = '{4'b0000, 32'h44332211, 3, 8'h44};
        vecs[10] = '{4'b0010, 32'h44332211, 1, 8'h22};
        vecs[11] = '{4'b1001, 32'h44332211, 3, 8'h44};
        vecs[12] = '{4'b0000, 32'h44332211, 0, 8'h11};

        nrst = 1'b0; req_valid = '0; req_data = '0; cfg_baud_set = 3'd3;
        tx_done = 1'b0; uart_state = 1'b0; pending = '0;
        #12;
        check_reset_outputs("rst");
        @(negedge clk);
        nrst = 1'b1;
        cfg_baud_set = BAUD_9600;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            pending  = pending | vecs[i].add;
            req_data = vecs[i].data;
            req_valid = pending;
            run_frame(vecs[i].exp_gnt, vecs[i].exp_byte);
        end

        // tx_done while idle must not start anything.
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        check("idle_done_busy", 32'(busy),    32'd0);
        check("idle_done_send", 32'(send_en), 32'd0);

        // Out-of-range baud code passes through while idle.
        cfg_baud_set = 3'd7;
        repeat (2) @(negedge clk);
        check("baud_pass7", 32'(baud_set), 32'd7);
        cfg_baud_set = BAUD_9600;
        repeat (2) @(negedge clk);
        check("baud_back0", 32'(baud_set), 32'd0);

        // Baud change during a frame is deferred; a dropped request is never granted.
        pending = 4'b0100; req_valid = pending;
        wait_grant(ok, lat);
        check("bf_ready", 32'(req_ready), 32'b0100);
        pending = '0; req_valid = '0;
        @(negedge clk);
        cfg_baud_set = BAUD_115200;
        req_valid = 4'b0001;
        @(negedge clk);
        req_valid = '0;
        check("bf_wait_baud", 32'(baud_set), 32'd0);
        repeat (3) @(negedge clk);
        check("bf_wait_baud2", 32'(baud_set), 32'd0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("bf_gap_baud1", 32'(baud_set), 32'd0);
        @(negedge clk);
        check("bf_gap_baud2", 32'(baud_set), 32'd0);
        repeat (3) @(negedge clk);
        check("bf_idle_baud", 32'(baud_set), 32'd4);
        check("bf_no_grant",  32'(busy),     32'd0);
        cfg_baud_set = BAUD_9600;

        // Reset mid-frame with requesters 1 and 3 pending and pointer at 3.
        pending = 4'b0100; req_valid = pending;
        wait_grant(ok, lat);
        check("rf_ready", 32'(req_ready), 32'b0100);
        pending = '0; req_valid = '0;
        @(negedge clk);
        pending = 4'b1010; req_valid = pending;
        @(negedge clk);
        check("rf_busy_before", 32'(busy), 32'd1);
        nrst = 1'b0;
        #1;
        check_reset_outputs("rf");
        @(negedge clk);
        nrst = 1'b1;
        run_frame(1, 8'h22);
        run_frame(3, 8'h44);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Watchdog expiry with tx_done withheld.
        pending = 4'b0001; req_valid = pending;
        wait_grant(ok, lat);
        pending = '0; req_valid = '0;
        cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cnt++;
            if (tx_err) break;
        end
        check("to_err_cycle", 32'(cnt), 32'd101);
        @(negedge clk);
        check("to_err_pulse", 32'(tx_err), 32'd0);
        check("to_gap_busy",  32'(busy),   32'd1);
        repeat (2) @(negedge clk);
        check("to_idle", 32'(busy), 32'd0);

        // tx_done on the expiry cycle wins.
        pending = 4'b0001; req_valid = pending;
        wait_grant(ok, lat);
        pending = '0; req_valid = '0;
        repeat (100) @(negedge clk);
        tx_done = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tx_done = 1'b0;
            if (tx_err) cnt++;
        end
        check("to_done_wins", 32'(cnt), 32'd0);
`endif

        check("final_err", 32'(tx_err), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
